// File: rtl/alarm_interval_timer_pkg.sv
// rtl/alarm_interval_timer_pkg.sv - shared interval codes and FSM state encoding for the alarm interval timer
package alarm_interval_timer_pkg;

  // Parameter-block select codes driven on the interval port
  typedef enum logic [1:0] {
    T_ARM_DELAY       = 2'b00,
    T_DRIVER_DELAY    = 2'b01,
    T_PASSENGER_DELAY = 2'b10,
    T_ALARM_ON        = 2'b11
  } interval_t;

  // Countdown FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    COUNT  = 2'b10,
    EXPIRE = 2'b11
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the clock down to a one-cycle tick every TICKS_PER_SEC enabled cycles
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] count_q;

  // The tick lands on the cycle whose edge sees the counter at its last value
  assign tick = enable && (count_q == LAST);

  // Count enabled cycles 0..TICKS_PER_SEC-1 and wrap; clear has priority over counting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tick ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_interval_timer.sv
// rtl/alarm_interval_timer.sv - countdown of a parameter-block interval in seconds; optional pause via ALARM_TIMER_PAUSE_EN
module alarm_interval_timer
  import alarm_interval_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval_req,
  input  logic       cancel,
`ifdef ALARM_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic [1:0] interval,
  input  logic [3:0] value,
  output logic       busy,
  output logic [3:0] remaining,
  output logic       expired
);

  state_t     state_q, state_d;
  logic [1:0] interval_q, interval_d;
  logic [3:0] remaining_q, remaining_d;
  logic       busy_q, busy_d;
  logic       expired_q, expired_d;
  logic       tick;
  logic       advance;
  logic       prescale_clear;

`ifdef ALARM_TIMER_PAUSE_EN
  assign advance = (state_q == COUNT) && !pause;
`else
  assign advance = (state_q == COUNT);
`endif

  // Prescaler restarts from zero every time a countdown (re)loads
  assign prescale_clear = (state_q != COUNT);

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (prescale_clear),
    .enable(advance),
    .tick  (tick)
  );

  // Next state: normal flow first, then cancel, then restart (cancel beats restart)
  always_comb begin
    state_d     = state_q;
    interval_d  = interval_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (start_timer && !cancel) begin
          interval_d = interval_req;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        remaining_d = value;
        state_d     = (value == 4'd0) ? EXPIRE : COUNT;
      end
      COUNT: begin
        if (tick && remaining_q != 4'd0) begin
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) state_d = EXPIRE;
        end
      end
      EXPIRE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cancel && (state_q == LOAD || state_q == COUNT)) begin
      state_d     = IDLE;
      remaining_d = 4'd0;
    end else if (start_timer && !cancel && state_q != IDLE) begin
      interval_d = interval_req;
      state_d    = LOAD;
    end
    busy_d    = (state_d == LOAD) || (state_d == COUNT);
    expired_d = (state_d == EXPIRE);
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      interval_q  <= 2'b00;
      remaining_q <= 4'd0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      interval_q  <= interval_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      expired_q   <= expired_d;
    end
  end

  assign interval  = interval_q;
  assign remaining = remaining_q;
  assign busy      = busy_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_alarm_interval_timer.sv
// tb/tb_alarm_interval_timer.sv - directed self-checking bench for alarm_interval_timer at TICKS_PER_SEC = 4
module tb_alarm_interval_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval_req;
  logic       cancel;
  logic [1:0] interval;
  logic [3:0] value;
  logic       busy;
  logic [3:0] remaining;
  logic       expired;
`ifdef ALARM_TIMER_PAUSE_EN
  logic       pause;
`endif

  int checks = 0;
  int failures = 0;

  alarm_interval_timer #(
    .TICKS_PER_SEC(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_timer (start_timer),
    .interval_req(interval_req),
    .cancel      (cancel),
`ifdef ALARM_TIMER_PAUSE_EN
    .pause       (pause),
`endif
    .interval    (interval),
    .value       (value),
    .busy        (busy),
    .remaining   (remaining),
    .expired     (expired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge where outputs are sampled
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic start(input logic [1:0] req, input logic [3:0] v);
    start_timer  = 1'b1;
    interval_req = req;
    value        = v;
    step(1);
    start_timer  = 1'b0;
  endtask

  function automatic logic [3:0] exp_rem3(input int k);
    if (k < 1) return 4'd0;
    if (k < 5) return 4'd3;
    if (k < 9) return 4'd2;
    if (k < 13) return 4'd1;
    return 4'd0;
  endfunction

  int pulses;

  initial begin
    reset = 1'b1; start_timer = 1'b0; interval_req = 2'b00; cancel = 1'b0; value = 4'd0;
`ifdef ALARM_TIMER_PAUSE_EN
    pause = 1'b0;
`endif
    step(2);
    check("rst_interval", 32'(interval), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_expired", 32'(expired), 32'd0);
    reset = 1'b0;
    step(1);

    // Basic V=3 countdown, interval 01
    start(2'b01, 4'd3);
    check("s1_interval", 32'(interval), 32'd1);
    check("s1_busy_load", 32'(busy), 32'd1);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      check($sformatf("s1_rem_k%0d", k), 32'(remaining), 32'(exp_rem3(k)));
      check($sformatf("s1_exp_k%0d", k), 32'(expired), (k == 13) ? 32'd1 : 32'd0);
      check($sformatf("s1_busy_k%0d", k), 32'(busy), (k < 13) ? 32'd1 : 32'd0);
    end

    // V=0 expires straight out of LOAD
    start(2'b11, 4'd0);
    check("s2_busy_load", 32'(busy), 32'd1);
    step(1);
    check("s2_expired", 32'(expired), 32'd1);
    check("s2_remaining", 32'(remaining), 32'd0);
    check("s2_busy", 32'(busy), 32'd0);
    step(1);
    check("s2_expired_end", 32'(expired), 32'd0);

    // Cancel at E+6
    start(2'b00, 4'd3);
    step(5);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check("s3_busy", 32'(busy), 32'd0);
    check("s3_remaining", 32'(remaining), 32'd0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (expired) pulses++;
    end
    check("s3_no_expired", 32'(pulses), 32'd0);

    // Restart at E+12 with interval 10, value 15
    start(2'b00, 4'd3);
    step(11);
    start(2'b10, 4'd15);
    check("s4_busy_reload", 32'(busy), 32'd1);
    check("s4_exp_e12", 32'(expired), 32'd0);
    step(1);
    check("s4_rem_e13", 32'(remaining), 32'd15);
    check("s4_interval", 32'(interval), 32'd2);
    step(1);
    check("s4_exp_e14", 32'(expired), 32'd0);
    pulses = 0;
    for (int k = 15; k <= 72; k++) begin
      step(1);
      if (expired) pulses++;
    end
    check("s4_no_early_exp", 32'(pulses), 32'd0);
    check("s4_rem_e72", 32'(remaining), 32'd1);
    step(1);
    check("s4_exp_e73", 32'(expired), 32'd1);
    step(1);
    check("s4_exp_e74", 32'(expired), 32'd0);
    check("s4_busy_e74", 32'(busy), 32'd0);

    // start and cancel together in IDLE: cancel wins, interval unchanged
    start_timer = 1'b1; cancel = 1'b1; interval_req = 2'b01; value = 4'd5;
    step(1);
    start_timer = 1'b0; cancel = 1'b0;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_interval", 32'(interval), 32'd2);
    step(1);
    check("s5_busy_later", 32'(busy), 32'd0);

    // Asynchronous reset mid-COUNT
    start(2'b11, 4'd5);
    step(6);
    check("s6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("s6_interval", 32'(interval), 32'd0);
    check("s6_remaining", 32'(remaining), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_expired", 32'(expired), 32'd0);
    step(1);
    reset = 1'b0;
    step(1);

`ifdef ALARM_TIMER_PAUSE_EN
    // Pause sampled at edges E+3..E+10 shifts expiry from E+9 to E+17
    start(2'b01, 4'd2);
    step(2);
    pause = 1'b1;
    step(8);
    pause = 1'b0;
    check("s7_busy_paused", 32'(busy), 32'd1);
    check("s7_rem_paused", 32'(remaining), 32'd2);
    pulses = 0;
    for (int k = 11; k <= 16; k++) begin
      step(1);
      if (expired) pulses++;
    end
    check("s7_no_early_exp", 32'(pulses), 32'd0);
    step(1);
    check("s7_exp_e17", 32'(expired), 32'd1);
    step(1);
    check("s7_exp_e18", 32'(expired), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
